// File: rtl/rf_wb_pkg.sv
// rtl/rf_wb_pkg.sv - shared widths, constants and FIFO entry type for the RF writeback controller
package rf_wb_pkg;

    localparam int REG_AW   = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;

    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

    // One buffered multi-cycle result: destination register and value.
    typedef struct packed {
        logic [REG_AW-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/rf_wb_fifo.sv
// rtl/rf_wb_fifo.sv - synchronous FIFO buffering multi-cycle results, head exposed without fall-through
import rf_wb_pkg::*;

module rf_wb_fifo #(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  logic      pop,
    input  wb_entry_t din,
    output wb_entry_t head,
    output logic      full,
    output logic      empty
);

    localparam int PW = $clog2(DEPTH);

    wb_entry_t        mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic [PW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Entry storage; the head is read from the old contents, so a same-cycle push never feeds the pop.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rf_writeback.sv
// rtl/rf_writeback.sv - RF write-port owner merging pipeline and multi-cycle results; optional bypass via WB_BYPASS_EN
import rf_wb_pkg::*;

module rf_writeback #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                PWr,
    input  logic [REG_AW-1:0]   PA,
    input  logic [DATA_W-1:0]   PD,
    input  logic                MValid,
    output logic                MReady,
    input  logic [REG_AW-1:0]   MA,
    input  logic [DATA_W-1:0]   MD,
    input  logic                IssueWr,
    input  logic [REG_AW-1:0]   IssueA,
    output logic [NUM_REGS-1:0] Busy,
    output logic [REG_AW-1:0]   A3,
    output logic [DATA_W-1:0]   WD,
    output logic                RFWr,
    input  logic [REG_AW-1:0]   RA1,
    input  logic [REG_AW-1:0]   RA2,
    output logic                Fwd1,
    output logic                Fwd2,
    output logic [DATA_W-1:0]   FwdD1,
    output logic [DATA_W-1:0]   FwdD2
);

    wb_entry_t           fifo_in;
    wb_entry_t           fifo_head;
    logic                fifo_full;
    logic                fifo_empty;
    logic                push;
    logic                pop;
    logic [NUM_REGS-1:0] busy_nxt;

    assign MReady  = !rst && !fifo_full;
    assign push    = MValid && MReady;
    // Pipeline results are never stalled, so the FIFO only drains in cycles without one.
    assign pop     = !PWr && !fifo_empty;
    assign fifo_in = '{addr: MA, data: MD};

    rf_wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (fifo_in),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Registered write port: pipeline first, then FIFO head; address/data hold when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            RFWr <= 1'b0;
            A3   <= '0;
            WD   <= '0;
        end else if (PWr) begin
            RFWr <= (PA != REG_ZERO);
            A3   <= PA;
            WD   <= PD;
        end else if (pop) begin
            RFWr <= (fifo_head.addr != REG_ZERO);
            A3   <= fifo_head.addr;
            WD   <= fifo_head.data;
        end else begin
            RFWr <= 1'b0;
        end
    end

    // Scoreboard update: pop clears, issue sets afterwards so a same-bit set wins; r0 never pending.
    always_comb begin
        busy_nxt = Busy;
        if (pop) begin
            busy_nxt[fifo_head.addr] = 1'b0;
        end
        if (IssueWr && (IssueA != REG_ZERO)) begin
            busy_nxt[IssueA] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk) begin
        if (rst) begin
            Busy <= '0;
        end else begin
            Busy <= busy_nxt;
        end
    end

`ifdef WB_BYPASS_EN
    assign Fwd1  = RFWr && (A3 == RA1) && (RA1 != REG_ZERO);
    assign Fwd2  = RFWr && (A3 == RA2) && (RA2 != REG_ZERO);
    assign FwdD1 = WD;
    assign FwdD2 = WD;
`else
    logic unused_ra;
    assign unused_ra = ^{RA1, RA2};
    assign Fwd1  = 1'b0;
    assign Fwd2  = 1'b0;
    assign FwdD1 = '0;
    assign FwdD2 = '0;
`endif

endmodule

// File: tb/tb_rf_writeback.sv
// tb/tb_rf_writeback.sv - self-checking scoreboard bench for rf_writeback
`timescale 1ns/1ps
import rf_wb_pkg::*;

module tb_rf_writeback;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        PWr = 1'b0;
    logic [4:0]  PA = '0;
    logic [31:0] PD = '0;
    logic        MValid = 1'b0;
    logic        MReady;
    logic [4:0]  MA = '0;
    logic [31:0] MD = '0;
    logic        IssueWr = 1'b0;
    logic [4:0]  IssueA = '0;
    logic [31:0] Busy;
    logic [4:0]  A3;
    logic [31:0] WD;
    logic        RFWr;
    logic [4:0]  RA1 = '0;
    logic [4:0]  RA2 = '0;
    logic        Fwd1;
    logic        Fwd2;
    logic [31:0] FwdD1;
    logic [31:0] FwdD2;

    rf_writeback #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .PWr(PWr), .PA(PA), .PD(PD),
        .MValid(MValid), .MReady(MReady), .MA(MA), .MD(MD),
        .IssueWr(IssueWr), .IssueA(IssueA), .Busy(Busy),
        .A3(A3), .WD(WD), .RFWr(RFWr), .RA1(RA1), .RA2(RA2),
        .Fwd1(Fwd1), .Fwd2(Fwd2), .FwdD1(FwdD1), .FwdD2(FwdD2)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        wr;
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t         exp_q[$];
    wb_entry_t   mq[$];
    logic [31:0] busy_m = '0;
    wr_t         cur = '0;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock: predict the next write-port state, push it, clock, pop and compare.
    task automatic step();
        wr_t       nxt;
        wb_entry_t h;
        logic      rdy;
        #1;
        rdy = !rst && (mq.size() < DEPTH);
        check("mready", 32'(MReady), 32'(rdy));
        if (rst) begin
            nxt    = '0;
            busy_m = '0;
            mq.delete();
        end else begin
            nxt = '{1'b0, cur.a, cur.d};
            if (PWr) begin
                nxt = '{(PA != 5'd0), PA, PD};
            end else if (mq.size() > 0) begin
                h = mq.pop_front();
                nxt = '{(h.addr != 5'd0), h.addr, h.data};
                busy_m[h.addr] = 1'b0;
            end
            if (MValid && rdy) mq.push_back('{addr: MA, data: MD});
            if (IssueWr && IssueA != 5'd0) busy_m[IssueA] = 1'b1;
        end
        exp_q.push_back(nxt);
        @(posedge clk);
        #1;
        nxt = exp_q.pop_front();
        cur = nxt;
        check("rfwr", 32'(RFWr), 32'(nxt.wr));
        check("a3", 32'(A3), 32'(nxt.a));
        check("wd", WD, nxt.d);
        check("busy", Busy, busy_m);
`ifdef WB_BYPASS_EN
        check("fwd1", 32'(Fwd1), 32'(nxt.wr && nxt.a == RA1 && RA1 != 5'd0));
        check("fwd2", 32'(Fwd2), 32'(nxt.wr && nxt.a == RA2 && RA2 != 5'd0));
        check("fwdd1", FwdD1, nxt.d);
        check("fwdd2", FwdD2, nxt.d);
`else
        check("fwd1", 32'(Fwd1), 32'd0);
        check("fwd2", 32'(Fwd2), 32'd0);
        check("fwdd1", FwdD1, 32'd0);
        check("fwdd2", FwdD2, 32'd0);
`endif
    endtask

    task automatic idle(input int n);
        PWr = 1'b0; MValid = 1'b0; IssueWr = 1'b0;
        repeat (n) step();
    endtask

    int k;

    initial begin
        // Reset
        step();
        step();
        check("rst_rfwr", 32'(RFWr), 32'd0);
        check("rst_a3", 32'(A3), 32'd0);
        check("rst_wd", WD, 32'd0);
        check("rst_busy", Busy, 32'd0);
        check("rst_mready", 32'(MReady), 32'd0);
        rst = 1'b0;
        #1;
        check("mready_after_rst", 32'(MReady), 32'd1);

        // Single pipeline write
        PWr = 1'b1; PA = 5'd5; PD = 32'hDEADBEEF;
        step();
        check("pipe_rfwr", 32'(RFWr), 32'd1);
        check("pipe_a3", 32'(A3), 32'd5);
        check("pipe_wd", WD, 32'hDEADBEEF);
        idle(1);
        check("pipe_single", 32'(RFWr), 32'd0);

        // Multi-cycle result with scoreboard
        IssueWr = 1'b1; IssueA = 5'd9;
        step();
        idle(1);
        MValid = 1'b1; MA = 5'd9; MD = 32'h1234;
        step();
        check("busy9_set", 32'(Busy[9]), 32'd1);
        idle(1);
        check("mc_rfwr", 32'(RFWr), 32'd1);
        check("mc_a3", 32'(A3), 32'd9);
        check("mc_wd", WD, 32'h1234);
        check("busy9_clr", 32'(Busy[9]), 32'd0);

        // Pipeline starvation while FIFO fills
        for (int i = 0; i < 4; i++) begin
            IssueWr = 1'b1; IssueA = 5'(10 + i);
            step();
        end
        IssueWr = 1'b0;
        k = 0;
        for (int c = 0; c < 6; c++) begin
            PWr = 1'b1; PA = 5'(c + 1); PD = 32'h100 + c;
            MValid = (k < 5); MA = 5'(10 + k); MD = 32'h2000 + k;
            if (MValid && mq.size() < DEPTH) k++;
            step();
        end
        #1;
        check("full_mready", 32'(MReady), 32'd0);
        check("full_accepts", 32'(k), 32'd4);
        idle(6);
        check("drain_busy", 32'(Busy[13:10]), 32'd0);

        // Register-zero writes
        PWr = 1'b1; PA = 5'd0; PD = 32'h77;
        step();
        check("r0_pipe", 32'(RFWr), 32'd0);
        PWr = 1'b0; MValid = 1'b1; MA = 5'd0; MD = 32'h55;
        IssueWr = 1'b1; IssueA = 5'd0;
        step();
        idle(1);
        check("r0_mc_rfwr", 32'(RFWr), 32'd0);
        check("r0_popped", WD, 32'h55);
        check("r0_busy", 32'(Busy[0]), 32'd0);

        // Same-cycle set and clear of one bit
        IssueWr = 1'b1; IssueA = 5'd3;
        step();
        IssueWr = 1'b0; MValid = 1'b1; MA = 5'd3; MD = 32'h333;
        step();
        MValid = 1'b0; IssueWr = 1'b1; IssueA = 5'd3;
        step();
        check("setwins_busy3", 32'(Busy[3]), 32'd1);
        check("setwins_a3", 32'(A3), 32'd3);
        IssueWr = 1'b0; MValid = 1'b1; MD = 32'h334;
        step();
        idle(2);
        check("busy3_final", 32'(Busy[3]), 32'd0);

        // Bypass compare
        RA1 = 5'd7; RA2 = 5'd0;
        PWr = 1'b1; PA = 5'd7; PD = 32'hCAFEF00D;
        step();
`ifdef WB_BYPASS_EN
        check("byp_fwd1", 32'(Fwd1), 32'd1);
        check("byp_fwdd1", FwdD1, 32'hCAFEF00D);
`else
        check("byp_fwd1", 32'(Fwd1), 32'd0);
        check("byp_fwdd1", FwdD1, 32'd0);
`endif
        check("byp_fwd2", 32'(Fwd2), 32'd0);
        idle(1);

        // Reset mid-operation
        IssueWr = 1'b1; IssueA = 5'd20;
        step();
        IssueA = 5'd21; PWr = 1'b1; PA = 5'd1; PD = 32'h1;
        MValid = 1'b1; MA = 5'd20; MD = 32'hA0;
        step();
        MA = 5'd21; MD = 32'hA1; IssueWr = 1'b0;
        step();
        rst = 1'b1; MValid = 1'b0;
        step();
        check("rstmid_rfwr", 32'(RFWr), 32'd0);
        rst = 1'b0;
        idle(3);
        check("rstmid_busy", Busy, 32'd0);
        check("rstmid_norf", 32'(RFWr), 32'd0);

        // Random traffic
        for (int c = 0; c < 80; c++) begin
            PWr     = ($urandom_range(0, 9) < 3);
            PA      = 5'($urandom_range(0, 31));
            PD      = $urandom;
            MValid  = ($urandom_range(0, 1) == 1);
            MA      = 5'($urandom_range(0, 31));
            MD      = $urandom;
            IssueWr = ($urandom_range(0, 3) == 0);
            IssueA  = 5'($urandom_range(0, 31));
            RA1     = 5'($urandom_range(0, 31));
            RA2     = 5'($urandom_range(0, 31));
            step();
        end
        idle(8);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rf_writeback.md
# rf_writeback

Writeback controller that owns the register file's single write port (A3/WD/RFWr). It merges results from the single-cycle pipeline and from the multi-cycle unit (mul/div), buffers multi-cycle results in a small FIFO, and maintains a 32-bit pending-destination scoreboard that decode uses to stall. It sits between the execute stage and the register file, on the writer side of the RF port.

## Interface
- FIFO_DEPTH, 4, multi-cycle result buffer entries; power of two, ≥2
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- PWr  in  1  pipeline writeback request this cycle; never stalled
- PA  in  5  pipeline destination register
- PD  in  32  pipeline result
- MValid  in  1  multi-cycle result valid
- MReady  out  1  multi-cycle result accepted when MValid && MReady
- MA  in  5  multi-cycle destination register
- MD  in  32  multi-cycle result
- IssueWr  in  1  decode issued a multi-cycle op; marks IssueA pending
- IssueA  in  5  destination of issued multi-cycle op
- Busy  out  32  scoreboard; bit i set = register i has a pending multi-cycle write
- A3  out  5  RF write address (registered)
- WD  out  32  RF write data (registered)
- RFWr  out  1  RF write enable (registered)
- RA1, RA2  in  5  decode read addresses (bypass compare)
- Fwd1, Fwd2  out  1  bypass hit for RA1/RA2
- FwdD1, FwdD2  out  32  bypass data for RA1/RA2

## Operation
- Each cycle selects at most one write source; pipeline has strict priority.
- PWr=1: output regs load {PA, PD}; RFWr next cycle = (PA != 0). FIFO not popped.
- PWr=0 and FIFO non-empty: pop head; output regs load {MA, MD} of head; RFWr next cycle = (head.MA != 0).
- Otherwise RFWr next cycle = 0; A3/WD hold previous values.
- FIFO push on MValid && MReady; MReady = !rst && !full (combinational). No fall-through: push and pop never involve the same entry in one cycle.
- Push and pop in the same cycle allowed when not full; count unchanged. Pointers wrap modulo FIFO_DEPTH.
- Scoreboard: IssueWr && IssueA != 0 sets Busy[IssueA] at the edge. A FIFO pop clears Busy[head.MA] at the same edge. Set and clear of the same bit in one cycle: set wins. Busy[0] always 0. Pipeline writes never touch Busy.
- Writes to register 0 still pop the FIFO but never assert RFWr.

## Timing
- Reset values: RFWr=0, A3=0, WD=0, Busy=0, FIFO empty, MReady=0 while rst high, 1 in the first cycle after.
- Pipeline latency: PWr in cycle N → RFWr in N+1 → RF value readable N+2.
- Multi-cycle latency (empty FIFO, no pipeline traffic): accept in N → pop in N+1 → RFWr in N+2; Busy bit clears at the N+1/N+2 edge.
- Continuous PWr starves the FIFO indefinitely; MReady drops once full.
- Reset mid-operation: FIFO contents and pending Busy bits discarded; no RF write issued after rst.

## Configuration
- WB_BYPASS_EN defined: Fwd1 = RFWr && A3 == RA1 && RA1 != 0, FwdD1 = WD (likewise for port 2). This lets decode see the value the RF is writing this cycle.
- Not defined: ports remain; Fwd1/Fwd2 = 0, FwdD1/FwdD2 = 0; RA1/RA2 ignored.

## Structure
- Package rf_wb_pkg: REG_AW=5, DATA_W=32, NUM_REGS=32, REG_ZERO=5'd0, and the FIFO entry struct {addr, data}.
- One sub-module: rf_wb_fifo (synchronous FIFO, DEPTH parameter, push/pop/full/empty, head output).

## Test plan
- Reset, then PWr=1, PA=5, PD=0xDEADBEEF → RFWr=1, A3=5, WD=0xDEADBEEF one cycle later; single cycle only.
- IssueWr IssueA=9; later MValid MA=9 MD=0x1234 → Busy[9]=1; RFWr with A3=9 two cycles after accept; Busy[9]=0 in the same cycle.
- PWr held for 6 cycles while 5 MValid results are offered (DEPTH=4) → MReady=0 after 4 accepts; FIFO drains in order once PWr drops.
- PWr PA=0 and FIFO entry MA=0 → RFWr stays 0; FIFO still empties; Busy[0] stays 0.
- Same-cycle IssueWr IssueA=3 and pop of MA=3 → Busy[3]=1 afterward.
- WB_BYPASS_EN: RFWr, A3=7, RA1=7, RA2=0 → Fwd1=1, FwdD1=WD, Fwd2=0. Without the macro → all bypass outputs 0.
